cmp_mask_packer: RTL and testbench

Collects per-lane compare flags produced by the vector ALU comparators and packs them into one vector mask register value, one bit per element. It sits downstream of the lane comparators and upstream of mask-register writeback. It accepts `LANES` flag pairs per beat over a valid/ready handshake, selects the requested flag per element, and presents the packed mask on a valid/ready output once `vl` elements have been gathered.

---
 rtl/cmp_mask_packer.sv | 130 +++++++++++++
 tb/tb_cmp_mask_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_mask_packer.sv
// Gathers per-lane comparator flags into a packed vector mask, one bit per element.
// Optional CMP_PACK_TAIL_UNDISTURBED_EN: tail elements keep old_mask_i instead of reading as 0.
module cmp_mask_packer #(
   parameter int unsigned LANES = 4,
   parameter int unsigned MAX_VL = 32,
   localparam int unsigned VlW = $clog2(MAX_VL + 1)
) (
   input  logic              module_clk_i,
   input  logic              module_rst_i,
   input  logic              start_i,
   input  logic [VlW-1:0]    vl_i,
   input  logic              sel_i,
   input  logic              flags_valid_i,
   output logic              flags_ready_o,
   input  logic [LANES-1:0]  lt_le_i,
   input  logic [LANES-1:0]  ge_gt_i,
   output logic [MAX_VL-1:0] mask_o,
   output logic              mask_valid_o,
   input  logic              mask_ready_i,
`ifdef CMP_PACK_TAIL_UNDISTURBED_EN
   input  logic [MAX_VL-1:0] old_mask_i,
`endif
   output logic              busy_o
);

   localparam int unsigned Beats = MAX_VL / LANES;
   localparam int unsigned BeatW = $clog2(Beats + 1);
   localparam int unsigned EndW  = VlW + 1;

   typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_e;

   state_e              state_q;
   logic                sel_q;
   logic [VlW-1:0]      vl_q;
   logic [BeatW-1:0]    beat_q;
   logic [MAX_VL-1:0]   acc_q;
   logic [MAX_VL-1:0]   mask_q;
   logic                mask_valid_q;
   logic                flags_ready_q;
   logic                busy_q;

   logic [VlW-1:0]      vl_eff;
   logic [MAX_VL-1:0]   acc_init;
   logic [MAX_VL-1:0]   acc_wr;
   logic [LANES-1:0]    flags_sel;
   logic [EndW-1:0]     beat_end;
   logic                last_beat;

   always_comb begin
      vl_eff = (vl_i > VlW'(MAX_VL)) ? VlW'(MAX_VL) : vl_i;
`ifdef CMP_PACK_TAIL_UNDISTURBED_EN
      acc_init = old_mask_i;
`else
      acc_init = '0;
`endif
   end

   // Only elements of the current beat below vl are written; tail bits keep their start value.
   always_comb begin
      flags_sel = sel_q ? ge_gt_i : lt_le_i;
      acc_wr    = acc_q;
      for (int unsigned i = 0; i < MAX_VL; i++) begin
         if ((BeatW'(i / LANES) == beat_q) && (VlW'(i) < vl_q)) begin
            acc_wr[i] = flags_sel[i % LANES];
         end
      end
      beat_end  = (EndW'(beat_q) + EndW'(1)) * EndW'(LANES);
      last_beat = (beat_end >= {1'b0, vl_q});
   end

   always_ff @(posedge module_clk_i or posedge module_rst_i) begin
      if (module_rst_i) begin
         state_q       <= StIdle;
         sel_q         <= 1'b0;
         vl_q          <= '0;
         beat_q        <= '0;
         acc_q         <= '0;
         mask_q        <= '0;
         mask_valid_q  <= 1'b0;
         flags_ready_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  sel_q  <= sel_i;
                  vl_q   <= vl_eff;
                  beat_q <= '0;
                  acc_q  <= acc_init;
                  busy_q <= 1'b1;
                  if (vl_eff != '0) begin
                     flags_ready_q <= 1'b1;
                     state_q       <= StCollect;
                  end else begin
                     mask_q       <= acc_init;
                     mask_valid_q <= 1'b1;
                     state_q      <= StOutput;
                  end
               end
            end
            StCollect: begin
               if (flags_valid_i) begin
                  acc_q  <= acc_wr;
                  beat_q <= beat_q + BeatW'(1);
                  if (last_beat) begin
                     mask_q        <= acc_wr;
                     mask_valid_q  <= 1'b1;
                     flags_ready_q <= 1'b0;
                     state_q       <= StOutput;
                  end
               end
            end
            StOutput: begin
               if (mask_ready_i) begin
                  mask_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mask_o        = mask_q;
   assign mask_valid_o  = mask_valid_q;
   assign flags_ready_o = flags_ready_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_cmp_mask_packer.sv
// Table-driven bench for cmp_mask_packer with an expected-mask scoreboard queue.
// Honours CMP_PACK_TAIL_UNDISTURBED_EN when the build defines it.
module tb_cmp_mask_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [5:0]  vl_i;
   logic        sel_i;
   logic        flags_valid_i;
   logic        flags_ready_o;
   logic [3:0]  lt_le_i;
   logic [3:0]  ge_gt_i;
   logic [31:0] mask_o;
   logic        mask_valid_o;
   logic        mask_ready_i;
   logic        busy_o;
   logic [31:0] old_mask;

   always #5 clk = ~clk;

   cmp_mask_packer #(.LANES(4), .MAX_VL(32)) dut (
      .module_clk_i  (clk),
      .module_rst_i  (rst),
      .start_i       (start_i),
      .vl_i          (vl_i),
      .sel_i         (sel_i),
      .flags_valid_i (flags_valid_i),
      .flags_ready_o (flags_ready_o),
      .lt_le_i       (lt_le_i),
      .ge_gt_i       (ge_gt_i),
      .mask_o        (mask_o),
      .mask_valid_o  (mask_valid_o),
      .mask_ready_i  (mask_ready_i),
`ifdef CMP_PACK_TAIL_UNDISTURBED_EN
      .old_mask_i    (old_mask),
`endif
      .busy_o        (busy_o)
   );

   typedef struct packed {
      logic [5:0]  vl;
      logic        sel;
      logic [1:0]  gap;
      logic [1:0]  stall;
      logic [31:0] lt;
      logic [31:0] ge;
      logic [31:0] old;
      logic [31:0] exp;   // expected mask with zero tail
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] final_exp(input vec_t v);
      int          vle = (v.vl > 6'd32) ? 32 : int'(v.vl);
      logic [31:0] keep = '0;
      for (int i = 0; i < vle; i++) keep[i] = 1'b1;
`ifdef CMP_PACK_TAIL_UNDISTURBED_EN
      return (v.exp & keep) | (v.old & ~keep);
`else
      return v.exp & keep;
`endif
   endfunction

   task automatic run_op(input vec_t v);
      int          vle = (v.vl > 6'd32) ? 32 : int'(v.vl);
      int          nb = (vle + 3) / 4;
      logic [31:0] held;
      logic [31:0] want;
      @(negedge clk);
      start_i  = 1'b1;
      vl_i     = v.vl;
      sel_i    = v.sel;
      old_mask = v.old;
      exp_q.push_back(final_exp(v));
      @(negedge clk);
      start_i  = 1'b0;
      old_mask = ~v.old;   // only the value present at start may matter
      check("busy_after_start", busy_o, 1);
      for (int b = 0; b < nb; b++) begin
         for (int g = 0; g < int'(v.gap); g++) begin
            flags_valid_i = 1'b0;
            if (b == 0 && g == 0) begin
               start_i = 1'b1;   // must be ignored while busy
               vl_i    = 6'd4;
               sel_i   = ~v.sel;
            end
            @(negedge clk);
            start_i = 1'b0;
         end
         check("flags_ready_in_collect", flags_ready_o, 1);
         flags_valid_i = 1'b1;
         lt_le_i = v.lt[b*4 +: 4];
         ge_gt_i = v.ge[b*4 +: 4];
         @(negedge clk);
      end
      flags_valid_i = 1'b0;
      check("mask_valid_after_last", mask_valid_o, 1);
      check("flags_ready_in_output", flags_ready_o, 0);
      check("busy_in_output", busy_o, 1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: got mask %h required a queued entry", mask_o);
      end else begin
         want = exp_q.pop_front();
         check("mask_value", mask_o, want);
      end
      held = mask_o;
      for (int s = 0; s < int'(v.stall); s++) begin
         flags_valid_i = 1'b1;
         lt_le_i = 4'hF;
         ge_gt_i = 4'hF;
         start_i = 1'b1;
         @(negedge clk);
         check("mask_stable_in_stall", mask_o, held);
         check("valid_held_in_stall", mask_valid_o, 1);
      end
      start_i       = 1'b0;
      flags_valid_i = 1'b0;
      mask_ready_i  = 1'b1;
      @(negedge clk);
      mask_ready_i  = 1'b0;
      check("valid_after_handshake", mask_valid_o, 0);
      check("busy_after_handshake", busy_o, 0);
   endtask

   initial begin
      vecs[0] = '{vl:6'd8,  sel:1'b0, gap:2'd0, stall:2'd0, lt:32'h0000_006A, ge:32'h0000_0055,
                  old:32'h0000_0000, exp:32'h0000_006A};
      vecs[1] = '{vl:6'd6,  sel:1'b1, gap:2'd0, stall:2'd0, lt:32'h0000_0000, ge:32'h0000_00FF,
                  old:32'hFFFF_FF00, exp:32'h0000_003F};
      vecs[2] = '{vl:6'd0,  sel:1'b0, gap:2'd0, stall:2'd1, lt:32'hFFFF_FFFF, ge:32'hFFFF_FFFF,
                  old:32'h1234_5678, exp:32'h0000_0000};
      vecs[3] = '{vl:6'd8,  sel:1'b0, gap:2'd2, stall:2'd3, lt:32'h0000_00C3, ge:32'hFFFF_FFFF,
                  old:32'h0F0F_0F0F, exp:32'h0000_00C3};
      vecs[4] = '{vl:6'd4,  sel:1'b0, gap:2'd0, stall:2'd0, lt:32'h0000_0001, ge:32'h0000_000E,
                  old:32'h0000_0000, exp:32'h0000_0001};
      vecs[5] = '{vl:6'd32, sel:1'b1, gap:2'd0, stall:2'd1, lt:32'hFFFF_FFFF, ge:32'h690F_3C5A,
                  old:32'hDEAD_BEEF, exp:32'h690F_3C5A};
      vecs[6] = '{vl:6'd40, sel:1'b1, gap:2'd1, stall:2'd2, lt:32'h0000_0000, ge:32'hA5A5_5A5A,
                  old:32'h0000_0000, exp:32'hA5A5_5A5A};
      vecs[7] = '{vl:6'd5,  sel:1'b0, gap:2'd0, stall:2'd0, lt:32'h0000_00FF, ge:32'h0000_0000,
                  old:32'hFFFF_FFFF, exp:32'h0000_001F};
      vecs[8] = '{vl:6'd13, sel:1'b1, gap:2'd1, stall:2'd0, lt:32'h0000_0000, ge:32'h0000_7FFF,
                  old:32'hF0F0_F0F0, exp:32'h0000_1FFF};
      vecs[9] = '{vl:6'd3,  sel:1'b0, gap:2'd0, stall:2'd0, lt:32'h0000_0009, ge:32'h0000_0006,
                  old:32'h8000_0000, exp:32'h0000_0001};

      rst = 1'b1;
      start_i = 1'b0; vl_i = '0; sel_i = 1'b0; flags_valid_i = 1'b0;
      lt_le_i = '0; ge_gt_i = '0; mask_ready_i = 1'b0; old_mask = '0;
      repeat (2) @(negedge clk);
      check("reset_mask", mask_o, 32'h0);
      check("reset_valid", mask_valid_o, 0);
      check("reset_ready", flags_ready_o, 0);
      check("reset_busy", busy_o, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_op(vecs[i]);

      // Abort after one of two beats: nothing may be emitted.
      @(negedge clk);
      start_i = 1'b1; vl_i = 6'd8; sel_i = 1'b0; old_mask = 32'hFFFF_0000;
      @(negedge clk);
      start_i = 1'b0;
      flags_valid_i = 1'b1; lt_le_i = 4'hF;
      @(negedge clk);
      flags_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("abort_mask", mask_o, 32'h0);
      check("abort_valid", mask_valid_o, 0);
      check("abort_ready", flags_ready_o, 0);
      check("abort_busy", busy_o, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_abort_valid", mask_valid_o, 0);
      check("post_abort_busy", busy_o, 0);
      run_op('{vl:6'd4, sel:1'b0, gap:2'd0, stall:2'd0, lt:32'h0000_0001, ge:32'h0000_0000,
               old:32'h0000_0000, exp:32'h0000_0001});

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
